// File: rtl/slice_add_seq.sv
// ---------------------------------------------------------------------------
// slice_add_seq
//   Wide (N_BIT*N_WORDS) add/subtract built by time-multiplexing one external
//   N_BIT-bit combinational adder slice. One slice is processed per cycle,
//   least significant first. The carry between slices lives in r_carry.
//
// Ports
//   clk, rst_n         rising-edge clock, async active-low reset
//   start, sub         request pulse (IDLE only) and op select (1 = A-B)
//   op_a, op_b         W-bit operands, latched with start
//   busy               high while in RUN or DONE
//   done               one-cycle pulse, result/c_out/overflow valid
//   result             W-bit sum/difference, held until next accepted start
//   c_out              final carry (for sub: 1 = no borrow)
//   overflow           two's-complement overflow of the W-bit operation
//   add_a/add_b/add_c_in  drive the external slice (zero outside RUN)
//   add_sum/add_c_out  combinational response of the external slice
// ---------------------------------------------------------------------------
module slice_add_seq #(
    parameter int N_BIT   = 4,
    parameter int N_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     sub,
    input  logic [N_BIT*N_WORDS-1:0] op_a,
    input  logic [N_BIT*N_WORDS-1:0] op_b,
    output logic                     busy,
    output logic                     done,
    output logic [N_BIT*N_WORDS-1:0] result,
    output logic                     c_out,
    output logic                     overflow,
    output logic [N_BIT-1:0]         add_a,
    output logic [N_BIT-1:0]         add_b,
    output logic                     add_c_in,
    input  logic [N_BIT-1:0]         add_sum,
    input  logic                     add_c_out
);

    localparam int IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                          r_state;
    logic [IW-1:0]                   r_idx;
    logic                            r_carry;
    logic                            r_sub;
    logic [N_WORDS-1:0][N_BIT-1:0]   r_a;
    logic [N_WORDS-1:0][N_BIT-1:0]   r_b;
    logic [N_WORDS-1:0][N_BIT-1:0]   r_result;
    logic                            r_c_out;
    logic                            r_ovf;
    logic                            r_done;

    logic                            w_run;
    logic                            w_a_msb;
    logic                            w_b_msb;
    logic                            w_ovf;

    assign w_run = (r_state == S_RUN);

    // Slice operands are gated to zero outside RUN so the external adder
    // sees a quiet bus while idle.
    assign add_a    = w_run ? r_a[r_idx] : '0;
    assign add_b    = w_run ? (r_b[r_idx] ^ {N_BIT{r_sub}}) : '0;
    assign add_c_in = w_run & r_carry;

    // Overflow uses the sign of the top slice's sum, so it is only
    // meaningful on the last RUN cycle, which is the only place it is used.
    assign w_a_msb = r_a[N_WORDS-1][N_BIT-1];
    assign w_b_msb = r_b[N_WORDS-1][N_BIT-1] ^ r_sub;
    assign w_ovf   = (w_a_msb == w_b_msb) && (add_sum[N_BIT-1] != w_a_msb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_sub    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_c_out  <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= op_a;
                        r_b     <= op_b;
                        r_sub   <= sub;
                        r_idx   <= '0;
                        // Subtraction is A + ~B + 1: seed the carry with sub.
                        r_carry <= sub;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_result[r_idx] <= add_sum;
                    r_carry         <= add_c_out;
                    if (r_idx == LAST) begin
                        // Flags are captured on the final slice so they are
                        // valid in the same cycle done is high.
                        r_c_out <= add_c_out;
                        r_ovf   <= w_ovf;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = (r_state == S_RUN) || (r_state == S_DONE);
    assign done     = r_done;
    assign result   = r_result;
    assign c_out    = r_c_out;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_slice_add_seq.sv
// ---------------------------------------------------------------------------
// tb_slice_add_seq
//   Scoreboard bench for slice_add_seq with default parameters (16-bit ops
//   over four 4-bit slices). The external adder slice is modelled here. The
//   expected {c_out, overflow, result} of each accepted request is computed
//   from whole-word integer arithmetic and queued; a monitor pops and compares
//   whenever done is observed.
// ---------------------------------------------------------------------------
module tb_slice_add_seq;

    localparam int N_BIT   = 4;
    localparam int N_WORDS = 4;
    localparam int W       = N_BIT * N_WORDS;
    localparam int LAT     = N_WORDS + 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             busy;
    logic             done;
    logic [W-1:0]     result;
    logic             c_out;
    logic             overflow;
    logic [N_BIT-1:0] add_a;
    logic [N_BIT-1:0] add_b;
    logic             add_c_in;
    logic [N_BIT-1:0] add_sum;
    logic             add_c_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [W+1:0] exp_q[$];

    slice_add_seq #(.N_BIT(N_BIT), .N_WORDS(N_WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .c_out     (c_out),
        .overflow  (overflow),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_c_in  (add_c_in),
        .add_sum   (add_sum),
        .add_c_out (add_c_out)
    );

    // External combinational adder slice.
    assign {add_c_out, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N_BIT{1'b0}}, add_c_in};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic, {c_out, overflow, result}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
        int ia, ib, r;
        logic [W-1:0] res;
        logic c, v;
        ia = $signed(a);
        ib = $signed(b);
        if (s) begin
            r   = ia - ib;
            res = a - b;
            c   = (a >= b);
        end else begin
            r   = ia + ib;
            res = a + b;
            c   = ((int'(a) + int'(b)) >= (1 << W));
        end
        v = (r > ((1 << (W-1)) - 1)) || (r < -(1 << (W-1)));
        return {c, v, res};
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: result 0x%0h with no request outstanding", result);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                chk("result",   32'(result),   32'(e[W-1:0]));
                chk("c_out",    32'(c_out),    32'(e[W+1]));
                chk("overflow", 32'(overflow), 32'(e[W]));
            end
        end
    end

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        sub   = s;
        start = 1'b1;
        exp_q.push_back(model(a, b, s));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Waits for done starting from the first RUN cycle (lat already 1).
    task automatic wait_done(input int lat0);
        int lat;
        lat = lat0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(LAT));
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] bm;
        bm = b ^ {W{s}};
        launch(a, b, s);
        @(negedge clk);
        chk("first_busy",    32'(busy),     32'd1);
        chk("first_add_a",   32'(add_a),    32'(a[N_BIT-1:0]));
        chk("first_add_b",   32'(add_b),    32'(bm[N_BIT-1:0]));
        chk("first_add_cin", 32'(add_c_in), 32'(s));
        wait_done(1);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_add_a", 32'(add_a), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_result",   32'(result),   32'd0);
        chk("rst_c_out",    32'(c_out),    32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_add_bus",  32'({add_a, add_b, add_c_in}), 32'd0);
        rst_n = 1'b1;

        // Directed corners.
        do_op(16'h1234, 16'h0FED, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1);
        do_op(16'h0005, 16'h0007, 1'b1);

        // Start while busy is ignored.
        launch(16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        op_a  = 16'h0001;
        op_b  = 16'h0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(2);
        repeat (4) @(negedge clk);
        chk("ignored_start_result", 32'(result), 32'h3333);
        chk("ignored_start_busy",   32'(busy),   32'd0);

        // Reset during the third RUN cycle aborts the operation.
        launch(16'h4321, 16'h1357, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",     32'(busy),     32'd0);
        chk("abort_done",     32'(done),     32'd0);
        chk("abort_result",   32'(result),   32'd0);
        chk("abort_c_out",    32'(c_out),    32'd0);
        chk("abort_overflow", 32'(overflow), 32'd0);
        chk("abort_add_bus",  32'({add_a, add_b, add_c_in}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h0003, 16'h0004, 1'b0);

        // Randomised traffic with a bias towards boundary operands.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 5))
                0: a = 16'h7FFF;
                1: b = 16'h8000;
                2: a = 16'hFFFF;
                3: b = 16'h0000;
                default: ;
            endcase
            do_op(a, b, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("outstanding_requests", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/slice_add_seq.md
Name: slice_add_seq

Overview:
Sequencer that performs wide (N_BIT*N_WORDS-bit) add/subtract by time-multiplexing one external N_BIT-bit ripple-carry adder slice, one slice per cycle, least significant slice first.
- Carry is held in a register between cycles.
- Sits between a requester (start/done handshake) and a combinational full-adder-chain instance whose ports it drives and samples.
- Frees the datapath from instantiating a full-width adder.

Parameters:
- N_BIT, 4, width of the external adder slice.
- N_WORDS, 4, number of slices per operand; operand width W = N_BIT*N_WORDS (16 by default).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- op_a  input  W  operand A; sampled with start.
- op_b  input  W  operand B; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when result is valid.
- result  output  W  sum/difference; held until the next accepted start.
- c_out  output  1  final carry out; for sub, 1 = no borrow.
- overflow  output  1  two's-complement overflow of the W-bit operation.
- add_a  output  N_BIT  A slice to the adder.
- add_b  output  N_BIT  B slice to the adder, inverted for sub.
- add_c_in  output  1  carry into the adder.
- add_sum  input  N_BIT  adder sum (combinational response).
- add_c_out  input  1  adder carry out (combinational response).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; idx, carry, result, c_out, overflow, done all 0; latched operands 0. add_a/add_b/add_c_in are 0 whenever state!=RUN.
- IDLE: if start=1, latch op_a, op_b, sub; set idx=0, carry=sub; go to RUN. Otherwise remain in IDLE.
- RUN (one slice per cycle):
  - add_a = A[idx*N_BIT +: N_BIT]; add_b = B slice XOR {N_BIT{sub}}; add_c_in = carry.
  - At the clock edge: result slice idx <= add_sum; carry <= add_c_out.
  - If idx == N_WORDS-1, go to DONE; else idx <= idx+1.
- DONE: done=1 for exactly one cycle; c_out = carry; overflow = (A[W-1] == B'[W-1]) && (result[W-1] != A[W-1]), where B' is B after the sub inversion. Then return to IDLE.
- Latency: start accepted at edge 0 → done high during cycle N_WORDS+1 (5 for defaults). Next start is accepted in the cycle after done, so throughput is one operation per N_WORDS+2 cycles.
- start while busy=1 is ignored entirely: no queuing, latched operands unchanged.
- result/c_out/overflow update only on slice writes and in DONE.
  - Mid-operation, result holds partial slices; it is valid only when done=1 and thereafter until the next accepted start.
  - The new operation's slices overwrite result progressively.
- Reset asserted mid-RUN: immediate return to IDLE, all outputs 0; no done pulse is produced for the aborted operation.
- Width rules:
  - idx is ceil(log2(N_WORDS)) bits, minimum 1.
  - N_WORDS=1 is legal: a single RUN cycle.
  - No wrap of idx beyond N_WORDS-1.
- The adder is treated as purely combinational within one cycle; no pipeline registers inside this block other than result/carry/idx.

Test Plan:
- Add 0x1234+0x0FED, sub=0 → done exactly 5 cycles after start; result=0x2221, c_out=0, overflow=0. Adder sees add_c_in=0 in the first RUN cycle.
- Add 0xFFFF+0x0001 → result=0x0000, c_out=1, overflow=0; carry propagates through all 4 slices.
- Add 0x7FFF+0x0001 → result=0x8000, c_out=0, overflow=1. Sub 0x8000-0x0001 → result=0x7FFF, c_out=1, overflow=1.
- Sub 0x0005-0x0007 → result=0xFFFE, c_out=0 (borrow), overflow=0. First RUN cycle shows add_b=0x8 (~0x7) and add_c_in=1.
- Pulse start with 0x0001+0x0001 while busy from 0x1111+0x2222 → first result 0x3333 with a single done pulse. The second start is ignored; result stays 0x3333.
- Assert rst_n=0 during the 3rd RUN cycle → busy, done, result, c_out and overflow are 0 immediately. After release, a new 0x0003+0x0004 gives 0x0007 in 5 cycles.
